// File: rtl/jesd204b_tx_ctrl.sv
// JESD204B transmit link controller: CGS / ILAS / DATA sequencing against the LMFC.
// Define JESD204B_TX_ILAS_EN to compile in the ILAS phase; otherwise CGS goes straight to DATA.
module jesd204b_tx_ctrl #(
  parameter int DATA_WIDTH      = 64,
  parameter int MF_CYCLES       = 4,
  parameter int SYNC_ERR_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sync_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [DATA_WIDTH/8-1:0] tx_charisk,
  output logic                    scr_en,
  output logic                    scr_reset,
  output logic [1:0]              state,
  output logic                    lmfc_edge
);
  localparam int NO = DATA_WIDTH / 8;
  localparam int CW = (MF_CYCLES > 1) ? $clog2(MF_CYCLES) : 1;
  localparam int LW = $clog2(SYNC_ERR_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MF_CYCLES - 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(SYNC_ERR_CYCLES - 1);

  typedef enum logic [1:0] {CGS = 2'b00, ILAS = 2'b01, DATA = 2'b10} st_t;

  st_t           st, st_nxt;
  logic          sync_m, sync_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [LW-1:0] low, low_nxt;

`ifdef JESD204B_TX_ILAS_EN
  logic [1:0]            m, m_nxt;
  logic [CW-1:0]         c, c_nxt;
  logic [DATA_WIDTH-1:0] ilas_data;
  logic [NO-1:0]         ilas_k;
`endif

  assign state = st;

  // Outputs are registered from next-state values so they line up with st and cnt.
  always_comb begin
    cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    st_nxt  = st;
    low_nxt = '0;
`ifdef JESD204B_TX_ILAS_EN
    m_nxt = '0;
    c_nxt = '0;
`endif
    case (st)
      CGS: begin
        if (sync_s && cnt == CNT_MAX) begin
`ifdef JESD204B_TX_ILAS_EN
          st_nxt = ILAS;
`else
          st_nxt = DATA;
`endif
        end
      end
`ifdef JESD204B_TX_ILAS_EN
      ILAS: begin
        if (!sync_s) st_nxt = CGS;
        else if (c == CNT_MAX) begin
          if (m == 2'd3) st_nxt = DATA;
          else           m_nxt  = m + 2'd1;
        end else begin
          m_nxt = m;
          c_nxt = c + CW'(1);
        end
      end
`endif
      DATA: begin
        if (!sync_s) begin
          if (low == LOW_MAX) st_nxt = CGS;
          else                low_nxt = low + LW'(1);
        end
      end
      default: st_nxt = CGS;
    endcase
  end

`ifdef JESD204B_TX_ILAS_EN
  // Ramp of octet indices with K markers at multiframe start/end and the config marker in MF 1.
  always_comb begin
    ilas_data = '0;
    ilas_k    = '0;
    for (int k = 0; k < NO; k++)
      ilas_data[DATA_WIDTH-1-8*k -: 8] = 8'((int'(m_nxt) * MF_CYCLES + int'(c_nxt)) * NO + k);
    if (c_nxt == '0) begin
      ilas_data[DATA_WIDTH-1 -: 8] = 8'h1C;
      ilas_k[NO-1] = 1'b1;
      if (m_nxt == 2'd1) begin
        ilas_data[DATA_WIDTH-9 -: 8] = 8'h9C;
        ilas_k[NO-2] = 1'b1;
      end
    end
    if (c_nxt == CNT_MAX) begin
      ilas_data[7:0] = 8'h7C;
      ilas_k[0] = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_m     <= 1'b0;
      sync_s     <= 1'b0;
      cnt        <= '0;
      st         <= CGS;
      low        <= '0;
      tx_data    <= '0;
      tx_charisk <= '0;
      scr_en     <= 1'b0;
      scr_reset  <= 1'b1;
      in_ready   <= 1'b0;
      lmfc_edge  <= 1'b0;
`ifdef JESD204B_TX_ILAS_EN
      m <= '0;
      c <= '0;
`endif
    end else begin
      sync_m    <= sync_n;
      sync_s    <= sync_m;
      cnt       <= cnt_nxt;
      st        <= st_nxt;
      low       <= low_nxt;
      lmfc_edge <= (cnt_nxt == '0);
`ifdef JESD204B_TX_ILAS_EN
      m <= m_nxt;
      c <= c_nxt;
`endif
      case (st_nxt)
`ifdef JESD204B_TX_ILAS_EN
        ILAS: begin
          tx_data    <= ilas_data;
          tx_charisk <= ilas_k;
          scr_en     <= 1'b0;
          scr_reset  <= 1'b1;
          in_ready   <= 1'b0;
        end
`endif
        DATA: begin
          tx_data    <= in_data;
          tx_charisk <= '0;
          scr_en     <= 1'b1;
          scr_reset  <= 1'b0;
          in_ready   <= 1'b1;
        end
        default: begin
          tx_data    <= {NO{8'hBC}};
          tx_charisk <= '1;
          scr_en     <= 1'b0;
          scr_reset  <= 1'b1;
          in_ready   <= 1'b0;
        end
      endcase
    end
  end
endmodule
